// File: rtl/rename_table_if.sv
// Rename-table port bundle: allocation, writeback and free ports plus the visible table state.
// The master side drives requests; the slave side (the table) drives responses and state.
interface rename_if #(parameter int PR_ADDR_W = 5);
  logic                     alloc_valid;
  logic [3:0]               alloc_arch;
  logic                     alloc_ready;
  logic [PR_ADDR_W-1:0]     alloc_phys;
  logic [PR_ADDR_W-1:0]     alloc_old_phys;
  logic                     wb_valid;
  logic [PR_ADDR_W-1:0]     wb_phys;
  logic                     free_valid;
  logic [PR_ADDR_W-1:0]     free_phys;
  logic [9:0]               rat_done;
  logic [PR_ADDR_W*10-1:0]  rat_aliases;
  logic [5:0]               free_count;
  logic                     overflow_err;

  modport master (
    output alloc_valid, alloc_arch, wb_valid, wb_phys, free_valid, free_phys,
    input  alloc_ready, alloc_phys, alloc_old_phys, rat_done, rat_aliases,
           free_count, overflow_err
  );

  modport slave (
    input  alloc_valid, alloc_arch, wb_valid, wb_phys, free_valid, free_phys,
    output alloc_ready, alloc_phys, alloc_old_phys, rat_done, rat_aliases,
           free_count, overflow_err
  );
endinterface

// File: rtl/rename_table.sv
// Register alias table for arch regs 2..11 with a 32-entry circular free list of physical registers.
// Arch regs 0/1 are hard-wired to phys 0/1 and never stored here.
module rename_table (
  input  logic    clk,
  input  logic    rst,
  rename_if.slave rif
);
  localparam int PW = 5;

  logic [PW-1:0] free_list [32];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [5:0]    count;
  logic [PW-1:0] alias_q [10];
  logic [9:0]    done_q;
  logic          err_q;

  logic          arch_ok;
  logic [3:0]    slot;
  logic          fire;
  logic          free_ok;
  logic          push;

  always_comb begin
    arch_ok = (rif.alloc_arch >= 4'd2) && (rif.alloc_arch <= 4'd11);
    slot    = rif.alloc_arch - 4'd2;
    // alloc_ready comes from the registered count only, so a same-cycle free is never bypassed
    fire    = rif.alloc_valid && (count != 6'd0) && arch_ok;
    free_ok = rif.free_valid && (rif.free_phys >= 5'd2);
    push    = free_ok && (count != 6'd32);
  end

  always_comb begin
    rif.alloc_ready = (count != 6'd0);
    rif.alloc_phys  = free_list[head];
    if (rif.alloc_arch < 4'd2)
      rif.alloc_old_phys = {4'd0, rif.alloc_arch[0]};
    else if (arch_ok)
      rif.alloc_old_phys = alias_q[slot];
    else
      rif.alloc_old_phys = '0;
    rif.free_count   = count;
    rif.overflow_err = err_q;
    rif.rat_done     = done_q;
    rif.rat_aliases  = '0;
    for (int i = 0; i < 10; i++)
      rif.rat_aliases[i*PW +: PW] = alias_q[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++)
        free_list[i] <= (i < 20) ? PW'(i + 12) : '0;
      for (int i = 0; i < 10; i++)
        alias_q[i] <= PW'(i + 2);
      done_q <= 10'h3FF;
      head   <= '0;
      tail   <= PW'(20);
      count  <= 6'd20;
      err_q  <= 1'b0;
    end else begin
      if (push) begin
        free_list[tail] <= rif.free_phys;
        tail            <= tail + 1'b1;
      end
      if (free_ok && (count == 6'd32))
        err_q <= 1'b1;
      if (fire)
        head <= head + 1'b1;
      case ({push, fire})
        2'b10:   count <= count + 6'd1;
        2'b01:   count <= count - 6'd1;
        default: count <= count;
      endcase
      if (rif.wb_valid && (rif.wb_phys >= 5'd2)) begin
        for (int i = 0; i < 10; i++)
          if (alias_q[i] == rif.wb_phys)
            done_q[i] <= 1'b1;
      end
      // Later assignment wins: a same-cycle writeback refers to the alias being replaced
      if (fire) begin
        alias_q[slot] <= free_list[head];
        done_q[slot]  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rename_table.sv
// Directed bench for rename_table: stimulus pushes expected values into a scoreboard queue,
// and a separate monitor pops and compares them against the DUT outputs.
module tb_rename_table;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rename_if rif ();
  rename_table dut (.clk(clk), .rst(rst), .rif(rif));

  typedef enum int {K_READY, K_PHYS, K_OLD, K_CNT, K_ERR, K_ALIAS, K_DONE, K_ALIASV, K_DONEV} kind_t;
  typedef struct {
    string       name;
    kind_t       kind;
    int          idx;
    logic [49:0] val;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  event chk_ev;

  logic [4:0] m_alias [10];
  logic [9:0] m_done;

  task automatic expect_v(input string name, input kind_t k, input int idx, input logic [49:0] v);
    exp_t e;
    e.name = name; e.kind = k; e.idx = idx; e.val = v;
    sbq.push_back(e);
  endtask

  function automatic logic [49:0] model_aliases();
    logic [49:0] v;
    for (int i = 0; i < 10; i++) v[i*5 +: 5] = m_alias[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 10; i++) m_alias[i] = 5'(i + 2);
    m_done = 10'h3FF;
  endtask

  task automatic expect_reset(input string tag);
    model_reset();
    expect_v({tag, "_ready"},   K_READY,  0, 50'd1);
    expect_v({tag, "_phys"},    K_PHYS,   0, 50'd12);
    expect_v({tag, "_count"},   K_CNT,    0, 50'd20);
    expect_v({tag, "_err"},     K_ERR,    0, 50'd0);
    expect_v({tag, "_done"},    K_DONEV,  0, 50'h3FF);
    expect_v({tag, "_aliases"}, K_ALIASV, 0, model_aliases());
  endtask

  function automatic logic [49:0] actual(input kind_t k, input int idx);
    case (k)
      K_READY:  return {49'd0, rif.alloc_ready};
      K_PHYS:   return {45'd0, rif.alloc_phys};
      K_OLD:    return {45'd0, rif.alloc_old_phys};
      K_CNT:    return {44'd0, rif.free_count};
      K_ERR:    return {49'd0, rif.overflow_err};
      K_ALIAS:  return {45'd0, rif.rat_aliases[idx*5 +: 5]};
      K_DONE:   return {49'd0, rif.rat_done[idx]};
      K_ALIASV: return rif.rat_aliases;
      K_DONEV:  return {40'd0, rif.rat_done};
      default:  return '0;
    endcase
  endfunction

  // Monitor: drains the scoreboard mid-cycle (negedge) or on demand for asynchronous checks
  initial begin
    exp_t e;
    logic [49:0] a;
    forever begin
      @(negedge clk or chk_ev);
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        a = actual(e.kind, e.idx);
        n_checks++;
        if (a !== e.val) begin
          n_fail++;
          $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, a, e.val);
        end
      end
    end
  end

  task automatic cyc(input bit av, input int arch, input bit wv, input int wp,
                     input bit fv, input int fp);
    @(posedge clk);
    #1;
    rif.alloc_valid = av;
    rif.alloc_arch  = 4'(arch);
    rif.wb_valid    = wv;
    rif.wb_phys     = 5'(wp);
    rif.free_valid  = fv;
    rif.free_phys   = 5'(fp);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int a;
    rif.alloc_valid = 0; rif.alloc_arch = 0; rif.wb_valid = 0;
    rif.wb_phys = 0; rif.free_valid = 0; rif.free_phys = 0;
    repeat (2) @(posedge clk);
    #1;
    expect_reset("rst_init");
    ->chk_ev;
    #1 rst = 1'b0;

    // first allocation of arch 5
    cyc(1, 5, 0, 0, 0, 0);
    expect_v("a5_phys", K_PHYS, 0, 50'd12);
    expect_v("a5_old",  K_OLD,  0, 50'd5);
    expect_v("a5_ready", K_READY, 0, 50'd1);
    expect_v("a5_count_before", K_CNT, 0, 50'd20);
    idle();
    expect_v("a5_alias", K_ALIAS, 3, 50'd12);
    expect_v("a5_done",  K_DONE,  3, 50'd0);
    expect_v("a5_count", K_CNT,   0, 50'd19);
    expect_v("a5_next_phys", K_PHYS, 0, 50'd13);
    m_alias[3] = 5'd12; m_done[3] = 1'b0;

    // stale writeback then matching writeback
    cyc(0, 0, 1, 5, 0, 0);
    expect_v("pre_wb_done", K_DONE, 3, 50'd0);
    cyc(0, 0, 1, 12, 0, 0);
    expect_v("stale_wb_done", K_DONE, 3, 50'd0);
    idle();
    expect_v("wb12_done", K_DONE, 3, 50'd1);
    expect_v("wb12_donev", K_DONEV, 0, 50'h3FF);
    m_done[3] = 1'b1;

    // alloc and writeback of the old alias in the same cycle: alloc wins
    cyc(1, 5, 1, 12, 0, 0);
    expect_v("collide_old",  K_OLD,  0, 50'd12);
    expect_v("collide_phys", K_PHYS, 0, 50'd13);
    idle();
    expect_v("collide_alias", K_ALIAS, 3, 50'd13);
    expect_v("collide_done",  K_DONE,  3, 50'd0);
    expect_v("collide_count", K_CNT,   0, 50'd18);
    m_alias[3] = 5'd13; m_done[3] = 1'b0;

    // drain the free list
    for (int k = 0; k < 18; k++) begin
      a = 2 + (k % 10);
      cyc(1, a, 0, 0, 0, 0);
      expect_v($sformatf("drain%0d_phys", k), K_PHYS, 0, 50'(14 + k));
      expect_v($sformatf("drain%0d_old", k),  K_OLD,  0, {45'd0, m_alias[a-2]});
      m_alias[a-2] = 5'(14 + k);
      m_done[a-2]  = 1'b0;
    end
    idle();
    expect_v("empty_count", K_CNT,   0, 50'd0);
    expect_v("empty_ready", K_READY, 0, 50'd0);
    expect_v("empty_aliases", K_ALIASV, 0, model_aliases());
    cyc(1, 4, 0, 0, 0, 0);
    expect_v("empty_req_ready", K_READY, 0, 50'd0);
    idle();
    expect_v("empty_ignored_count",   K_CNT,    0, 50'd0);
    expect_v("empty_ignored_aliases", K_ALIASV, 0, model_aliases());
    expect_v("empty_ignored_done",    K_DONEV,  0, {40'd0, m_done});

    // alloc with empty list while freeing phys 7
    cyc(1, 4, 0, 0, 1, 7);
    expect_v("free7_ready_now", K_READY, 0, 50'd0);
    expect_v("free7_count_now", K_CNT,   0, 50'd0);
    idle();
    expect_v("free7_ready", K_READY, 0, 50'd1);
    expect_v("free7_phys",  K_PHYS,  0, 50'd7);
    expect_v("free7_count", K_CNT,   0, 50'd1);
    expect_v("free7_aliases", K_ALIASV, 0, model_aliases());

    // simultaneous alloc and free: count unchanged, no bypass of the freed entry
    cyc(1, 10, 0, 0, 1, 9);
    expect_v("simul_phys",  K_PHYS, 0, 50'd7);
    expect_v("simul_count", K_CNT,  0, 50'd1);
    m_alias[8] = 5'd7; m_done[8] = 1'b0;
    idle();
    expect_v("simul_count_after", K_CNT,   0, 50'd1);
    expect_v("simul_alias",       K_ALIAS, 8, 50'd7);
    expect_v("simul_done",        K_DONE,  8, 50'd0);
    expect_v("simul_next_phys",   K_PHYS,  0, 50'd9);

    // free of phys 1 is ignored
    cyc(0, 0, 0, 0, 1, 1);
    idle();
    expect_v("free1_count", K_CNT, 0, 50'd1);

    // fill to 32 (tail wraps), then overflow
    for (int k = 0; k < 31; k++) cyc(0, 0, 0, 0, 1, 2 + (k % 30));
    idle();
    expect_v("full_count", K_CNT, 0, 50'd32);
    expect_v("full_err",   K_ERR, 0, 50'd0);
    expect_v("full_phys",  K_PHYS, 0, 50'd9);
    cyc(0, 0, 0, 0, 1, 20);
    idle();
    expect_v("ovf_count", K_CNT, 0, 50'd32);
    expect_v("ovf_err",   K_ERR, 0, 50'd1);

    // out-of-range arch requests change nothing
    cyc(1, 0, 0, 0, 0, 0);
    expect_v("arch0_old",   K_OLD,   0, 50'd0);
    expect_v("arch0_ready", K_READY, 0, 50'd1);
    cyc(1, 12, 0, 0, 0, 0);
    idle();
    expect_v("badarch_count",   K_CNT,    0, 50'd32);
    expect_v("badarch_aliases", K_ALIASV, 0, model_aliases());
    expect_v("badarch_done",    K_DONEV,  0, {40'd0, m_done});
    expect_v("badarch_err",     K_ERR,    0, 50'd1);

    // writeback for arch 11 (alias 23)
    cyc(0, 0, 1, 23, 0, 0);
    idle();
    expect_v("wb23_done", K_DONE, 9, 50'd1);
    expect_v("wb23_other", K_DONE, 8, 50'd0);

    // asynchronous reset in the middle of a burst
    cyc(1, 6, 0, 0, 1, 3);
    cyc(1, 7, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    expect_reset("rst_async");
    ->chk_ev;
    #1;
    rif.alloc_valid = 0; rif.free_valid = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    idle();
    expect_reset("rst_after");

    for (int w = 0; w < 20 && sbq.size() > 0; w++) @(posedge clk);
    if (sbq.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d scoreboard entries left, expected 0", sbq.size());
    end
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
